skid_buffer: RTL

// - Two-entry ready/valid register slice that registers the backward (ready) path as well as the forward path.
// - The single-entry elastic stage passes ready_i combinationally to ready_o; this block does not.
// - Inserted where a long ready chain limits timing: between pipeline stages, ahead of sinks with slow backpressure.
// - Sustains 1 transfer/cycle with no combinational path from ready_i to ready_o or from valid_i to valid_o.
//

---
 rtl/skid_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry ready/valid slice registering both ready and valid paths; SKID_BUFFER_STATS_EN adds stall_count_o.
// Latency: 1 cycle from in_fire to valid_o when empty, 1 word/cycle sustained.
// Backpressure: ready_o drops one cycle after ready_i stalls; skid_r absorbs the word already in flight.

module skid_buffer #(
    parameter int width_p          = 8,
    parameter bit datapath_reset_p = 1'b0
`ifdef SKID_BUFFER_STATS_EN
    ,
    parameter int counter_width_p  = 16
`endif
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i
`ifdef SKID_BUFFER_STATS_EN
    ,
    output logic [counter_width_p-1:0] stall_count_o
`endif
);

    typedef enum logic [1:0] {
        empty_s = 2'd0,
        busy_s  = 2'd1,
        full_s  = 2'd2
    } state_e;

    state_e             state_r;
    logic [width_p-1:0] main_r;
    logic [width_p-1:0] skid_r;
    logic               in_fire;
    logic               out_fire;
    logic               load_main;
    logic               load_skid;

    // ready_o depends only on registered state (plus reset), never on ready_i.
    assign ready_o  = (state_r != full_s) & ~reset_i;
    assign valid_o  = (state_r != empty_s);
    assign data_o   = main_r;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    assign load_main = ((state_r == empty_s) & in_fire)
                     | ((state_r == busy_s) & in_fire & out_fire)
                     | ((state_r == full_s) & out_fire);
    assign load_skid = (state_r == busy_s) & in_fire & ~out_fire;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= empty_s;
        end else begin
            case (state_r)
                empty_s: if (in_fire) state_r <= busy_s;
                busy_s: begin
                    if (in_fire & ~out_fire)      state_r <= full_s;
                    else if (~in_fire & out_fire) state_r <= empty_s;
                end
                full_s:  if (out_fire) state_r <= busy_s;
                default: state_r <= empty_s;
            endcase
        end
    end

    // Without datapath reset the payload registers simply hold through reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (datapath_reset_p) begin
                main_r <= '0;
                skid_r <= '0;
            end
        end else begin
            if (load_main) main_r <= (state_r == full_s) ? skid_r : data_i;
            if (load_skid) skid_r <= data_i;
        end
    end

`ifdef SKID_BUFFER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_count_o <= '0;
        end else if (valid_o & ~ready_i & ~(&stall_count_o)) begin
            stall_count_o <= stall_count_o + 1'b1;
        end
    end
`endif

endmodule
